// File: rtl/if_xfer_scheduler_pkg.sv
// Shared definitions for the interface transfer scheduler: transfer codes,
// source indices, FSM states and small decode helpers.
package if_pkg;

   localparam int N_SRC = 6;

   localparam logic [2:0] SRC_FLGWEI = 3'd0;
   localparam logic [2:0] SRC_WEI    = 3'd1;
   localparam logic [2:0] SRC_FLGACT = 3'd2;
   localparam logic [2:0] SRC_ACT    = 3'd3;
   localparam logic [2:0] SRC_FLGOFM = 3'd4;
   localparam logic [2:0] SRC_OFM    = 3'd5;

   localparam logic [3:0] CODE_CFG    = 4'd0;
   localparam logic [3:0] CODE_FLGWEI = 4'd8;
   localparam logic [3:0] CODE_WEI    = 4'd6;
   localparam logic [3:0] CODE_FLGACT = 4'd4;
   localparam logic [3:0] CODE_ACT    = 4'd2;
   localparam logic [3:0] CODE_FLGOFM = 4'd10;
   localparam logic [3:0] CODE_OFM    = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [3:0] src_code(input logic [2:0] idx);
      logic [3:0] code;
      case (idx)
         SRC_FLGWEI: code = CODE_FLGWEI;
         SRC_WEI:    code = CODE_WEI;
         SRC_FLGACT: code = CODE_FLGACT;
         SRC_ACT:    code = CODE_ACT;
         SRC_FLGOFM: code = CODE_FLGOFM;
         SRC_OFM:    code = CODE_OFM;
         default:    code = CODE_CFG;
      endcase
      return code;
   endfunction

   // Only the output buffers move data chip->host.
   function automatic logic code_rdwr(input logic [3:0] code);
      return !((code == CODE_FLGOFM) || (code == CODE_OFM));
   endfunction

   function automatic logic [2:0] onehot_idx(input logic [5:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < N_SRC; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/if_xfer_scheduler_rr_pick.sv
// Combinational 6-way round-robin picker: first eligible source at or after
// the pointer, searching upward and wrapping 5 -> 0.
module if_rr_pick
   import if_pkg::*;
(
   input  logic [5:0] elig,
   input  logic [2:0] ptr,
   output logic [5:0] pick,
   output logic       valid
);

   logic [2:0] base;
   logic [3:0] idx;

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      idx   = '0;
      base  = (ptr > 3'd5) ? 3'd0 : ptr;
      for (int k = 0; k < N_SRC; k++) begin
         idx = {1'b0, base} + 4'(k);
         if (idx >= 4'd6) idx = idx - 4'd6;
         if (!valid && elig[idx[2:0]]) begin
            pick[idx[2:0]] = 1'b1;
            valid          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_xfer_scheduler.sv
// Transfer scheduler for the host SPI/async-FIFO interface: picks config or a
// global buffer, issues a one-cycle request, counts beats, guards with a watchdog.
//
//   state   | meaning
//   IDLE    | waiting for cfg_req or an eligible buffer
//   REQ     | winner latched, waiting for if_rdy to fire if_req
//   XFER    | counting data beats up to the latched length
//   DONE    | one cycle: release grant, advance RR for data sources
module if_xfer_scheduler
   import if_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int BURST_LEN = 64,
   parameter int CFG_LEN   = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                cfg_req,
   input  logic                flush_ofm,
   input  logic [6*ADDR_W-1:0] src_wptr,
   input  logic [6*ADDR_W-1:0] src_rptr,
   input  logic                beat,
   input  logic                if_rdy,
   output logic                if_req,
   output logic [3:0]          if_cfg,
   output logic                if_rdwr,
   output logic                busy,
   output logic [6:0]          grant,
   output logic                timeout_err
);

   localparam logic [ADDR_W-1:0] BURST_W = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] CFG_W   = ADDR_W'(CFG_LEN);
   localparam logic [ADDR_W-1:0] FULL_W  = '1;
   localparam int                WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]   WD_LOAD = WD_W'(TIMEOUT - 1);

   state_t            state;
   logic [2:0]        win_idx;
   logic              win_cfg;
   logic [ADDR_W-1:0] xfer_len;
   logic [ADDR_W-1:0] beat_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic [2:0]        rr_ptr;

   logic [ADDR_W-1:0] occ      [N_SRC];
   logic [ADDR_W-1:0] len_cand [N_SRC];
   logic [5:0]        elig;
   logic [5:0]        pick;
   logic              pick_valid;
   logic [2:0]        pick_idx;
   logic [3:0]        pick_code;
   logic [ADDR_W-1:0] beat_inc;
   logic [2:0]        rr_adv;
   logic              wd_expire;

   // Input buffers need room for a full burst; output buffers need a full
   // burst of data, or any data at all while flushing.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_SRC; i++) begin
         occ[i] = src_wptr[i*ADDR_W +: ADDR_W] - src_rptr[i*ADDR_W +: ADDR_W];
         if (i < 4) begin
            elig[i]     = (FULL_W - occ[i]) >= BURST_W;
            len_cand[i] = BURST_W;
         end else begin
            elig[i]     = (occ[i] >= BURST_W) || (flush_ofm && (occ[i] != '0));
            len_cand[i] = (occ[i] < BURST_W) ? occ[i] : BURST_W;
         end
      end
   end

   if_rr_pick u_rr_pick (
      .elig  (elig),
      .ptr   (rr_ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   assign pick_idx  = onehot_idx(pick);
   assign pick_code = src_code(pick_idx);
   assign beat_inc  = beat_cnt + 1'b1;
   assign rr_adv    = (win_idx == 3'd5) ? 3'd0 : win_idx + 3'd1;
   assign wd_expire = ((state == ST_REQ) || ((state == ST_XFER) && !beat))
                      && (wd_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         win_idx     <= '0;
         win_cfg     <= 1'b0;
         xfer_len    <= '0;
         beat_cnt    <= '0;
         wd_cnt      <= '0;
         rr_ptr      <= '0;
         if_req      <= 1'b0;
         if_cfg      <= '0;
         if_rdwr     <= 1'b1;
         busy        <= 1'b0;
         grant       <= '0;
         timeout_err <= 1'b0;
      end else if (clr) begin
         state       <= ST_IDLE;
         beat_cnt    <= '0;
         wd_cnt      <= '0;
         if_req      <= 1'b0;
         busy        <= 1'b0;
         grant       <= '0;
         timeout_err <= 1'b0;
      end else begin
         if_req <= 1'b0;
         if (wd_expire) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            grant       <= '0;
            beat_cnt    <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
            if (!win_cfg) rr_ptr <= rr_adv;
         end else begin
            case (state)
               ST_IDLE: begin
                  beat_cnt <= '0;
                  wd_cnt   <= WD_LOAD;
                  if (cfg_req) begin
                     win_cfg  <= 1'b1;
                     if_cfg   <= CODE_CFG;
                     if_rdwr  <= code_rdwr(CODE_CFG);
                     xfer_len <= CFG_W;
                     grant    <= 7'b100_0000;
                     busy     <= 1'b1;
                     state    <= ST_REQ;
                  end else if (pick_valid) begin
                     win_cfg  <= 1'b0;
                     win_idx  <= pick_idx;
                     if_cfg   <= pick_code;
                     if_rdwr  <= code_rdwr(pick_code);
                     xfer_len <= len_cand[pick_idx];
                     grant    <= {1'b0, pick};
                     busy     <= 1'b1;
                     state    <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  wd_cnt <= wd_cnt - 1'b1;
                  if (if_rdy) begin
                     if_req <= 1'b1;
                     state  <= ST_XFER;
                  end
               end
               ST_XFER: begin
                  if (beat) begin
                     beat_cnt <= beat_inc;
                     wd_cnt   <= WD_LOAD;
                     if (beat_inc == xfer_len) state <= ST_DONE;
                  end else begin
                     wd_cnt <= wd_cnt - 1'b1;
                  end
               end
               ST_DONE: begin
                  busy     <= 1'b0;
                  grant    <= '0;
                  beat_cnt <= '0;
                  if (!win_cfg) rr_ptr <= rr_adv;
                  state    <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_xfer_scheduler.sv
// Scoreboard bench for if_xfer_scheduler: directed pointer scenarios push the
// expected {code, rdwr, grant} per request; a negedge monitor pops and compares.
module tb_if_xfer_scheduler;

   localparam int ADDR_W = 12;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clr = 1'b0;
   logic                cfg_req = 1'b0;
   logic                flush_ofm = 1'b0;
   logic [6*ADDR_W-1:0] src_wptr;
   logic [6*ADDR_W-1:0] src_rptr;
   logic                beat = 1'b0;
   logic                if_rdy = 1'b0;
   logic                if_req;
   logic [3:0]          if_cfg;
   logic                if_rdwr;
   logic                busy;
   logic [6:0]          grant;
   logic                timeout_err;

   logic [ADDR_W-1:0] wp [6];
   logic [ADDR_W-1:0] rp [6];

   logic [11:0] exp_q [$];
   int n_cmp = 0;
   int n_err = 0;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 6; i++) begin
         src_wptr[i*ADDR_W +: ADDR_W] = wp[i];
         src_rptr[i*ADDR_W +: ADDR_W] = rp[i];
      end
   end

   if_xfer_scheduler #(
      .ADDR_W(12), .BURST_LEN(64), .CFG_LEN(16), .TIMEOUT(4096)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .cfg_req     (cfg_req),
      .flush_ofm   (flush_ofm),
      .src_wptr    (src_wptr),
      .src_rptr    (src_rptr),
      .beat        (beat),
      .if_rdy      (if_rdy),
      .if_req      (if_req),
      .if_cfg      (if_cfg),
      .if_rdwr     (if_rdwr),
      .busy        (busy),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   // Monitor: every request pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      logic [11:0] e;
      if (rst_n && if_req) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got cfg=%0d rdwr=%0d grant=%b, none expected",
                     if_cfg, if_rdwr, grant);
         end else begin
            e = exp_q.pop_front();
            if ({if_cfg, if_rdwr, grant} !== e) begin
               n_err++;
               $display("FAIL sb_req: got cfg=%0d rdwr=%0d grant=%b, expected cfg=%0d rdwr=%0d grant=%b",
                        if_cfg, if_rdwr, grant, e[11:8], e[7], e[6:0]);
            end
         end
         n_cmp++;
         if (req_prev !== 1'b0) begin
            n_err++;
            $display("FAIL req_width: if_req high on consecutive cycles");
         end
      end
      req_prev <= if_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_if_req"}, int'(if_req), 0);
      check({tag, "_if_cfg"}, int'(if_cfg), 0);
      check({tag, "_if_rdwr"}, int'(if_rdwr), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_grant"}, int'(grant), 0);
      check({tag, "_timeout_err"}, int'(timeout_err), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
   endtask

   task automatic set_ptr(input int i, input int w, input int r);
      wp[i] = ADDR_W'(w);
      rp[i] = ADDR_W'(r);
   endtask

   task automatic push_exp(input logic [3:0] code, input logic rdwr, input logic [6:0] g);
      exp_q.push_back({code, rdwr, g});
   endtask

   // Raise if_rdy and wait (bounded) for the request pulse; cyc = edges taken.
   task automatic wait_req(output int cyc, input logic junk_beat);
      bit seen;
      seen   = 1'b0;
      cyc    = 0;
      if_rdy = 1'b1;
      beat   = junk_beat;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         cyc++;
         if (if_req) seen = 1'b1;
      end
      if_rdy = 1'b0;
      beat   = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_timeout: got no if_req within %0d cycles, expected one", cyc);
      end
   endtask

   // Drive n beats with a gap before the last one; busy must survive the gap
   // and drop exactly one cycle after the final beat.
   task automatic run_xfer(input int n);
      beat = 1'b1;
      repeat (n - 1) tick();
      beat = 1'b0;
      tick();
      check("busy_mid", int'(busy), 1);
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick();
      check("busy_end", int'(busy), 0);
   endtask

   initial begin
      int cyc;
      int n;
      logic [3:0] rr_codes [4];
      logic [6:0] rr_grants [4];
      rr_codes  = '{4'd8, 4'd6, 4'd4, 4'd2};
      rr_grants = '{7'h01, 7'h02, 7'h04, 7'h08};

      // Config beats WEI, then WEI follows; clr and rst_n mid-transfer.
      for (int i = 0; i < 6; i++) set_ptr(i, 0, 0);
      set_ptr(0, 4095, 0);
      set_ptr(2, 4095, 0);
      set_ptr(3, 4095, 0);
      cfg_req = 1'b1;
      if_rdy  = 1'b1;
      do_reset();
      push_exp(4'd0, 1'b1, 7'h40);
      wait_req(cyc, 1'b0);
      cfg_req = 1'b0;
      check("lat_cfg", cyc, 2);
      run_xfer(16);
      push_exp(4'd6, 1'b1, 7'h02);
      wait_req(cyc, 1'b1);
      check("turnaround", cyc, 2);
      beat = 1'b1;
      repeat (30) tick();
      beat = 1'b0;
      clr  = 1'b1;
      tick();
      clr  = 1'b0;
      check("clr_busy", int'(busy), 0);
      check("clr_grant", int'(grant), 0);
      check("clr_if_req", int'(if_req), 0);
      push_exp(4'd6, 1'b1, 7'h02);
      wait_req(cyc, 1'b0);
      run_xfer(64);
      push_exp(4'd6, 1'b1, 7'h02);
      wait_req(cyc, 1'b0);
      beat = 1'b1;
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      beat = 1'b0;
      check_reset_outputs("rst_mid");

      // Round-robin over the four input buffers, 64 beats each.
      for (int i = 0; i < 6; i++) set_ptr(i, 0, 0);
      do_reset();
      for (int t = 0; t < 4; t++) begin
         push_exp(rr_codes[t], 1'b1, rr_grants[t]);
         wait_req(cyc, 1'b1);
         check("lat_rr", cyc, 2);
         run_xfer(64);
      end

      // OFM short burst only under flush; latched length ignores pointer moves.
      for (int i = 0; i < 4; i++) set_ptr(i, 4095, 0);
      set_ptr(4, 0, 0);
      set_ptr(5, 20, 0);
      flush_ofm = 1'b0;
      do_reset();
      repeat (10) tick();
      check("ofm_noflush_busy", int'(busy), 0);
      check("ofm_noflush_grant", int'(grant), 0);
      flush_ofm = 1'b1;
      push_exp(4'd11, 1'b0, 7'h20);
      wait_req(cyc, 1'b0);
      check("lat_ofm", cyc, 2);
      set_ptr(5, 40, 0);
      run_xfer(20);
      flush_ofm = 1'b0;

      // Watchdog in REQ, RR advance on abort, clr clears the sticky flag.
      for (int i = 0; i < 6; i++) set_ptr(i, 0, 0);
      set_ptr(0, 4095, 0);
      set_ptr(1, 4095, 0);
      set_ptr(3, 4095, 0);
      do_reset();
      tick();
      check("to_req_busy", int'(busy), 1);
      n = 0;
      for (int k = 0; k < 5000 && !timeout_err; k++) begin
         tick();
         n++;
      end
      check("wd_cycles", n, 4096);
      check("to_busy", int'(busy), 0);
      set_ptr(3, 0, 0);
      push_exp(4'd2, 1'b1, 7'h08);
      wait_req(cyc, 1'b0);
      check("lat_after_to", cyc, 2);
      check("to_sticky", int'(timeout_err), 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("to_clr", int'(timeout_err), 0);

      // Pointer wrap on FLGWEI.
      for (int i = 0; i < 6; i++) set_ptr(i, 0, 0);
      for (int i = 1; i < 4; i++) set_ptr(i, 4095, 0);
      set_ptr(0, 4090, 4060);
      do_reset();
      tick();
      tick();
      check("wrap30_busy", int'(busy), 1);
      check("wrap30_grant", int'(grant), 1);
      set_ptr(0, 2, 4090);
      do_reset();
      tick();
      tick();
      check("wrap8_busy", int'(busy), 1);
      check("wrap8_grant", int'(grant), 1);
      set_ptr(0, 4030, 4086);
      do_reset();
      tick();
      tick();
      check("wrap4040_busy", int'(busy), 0);

      check("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
